// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and frame sequencer feeding uart_tx: buffers user bytes and
// hands them to the UART one frame at a time, waiting for tx_done in between.
module uart_tx_fifo #(
  parameter int data_width = 8,
  parameter int depth      = 16,
  parameter int addr_width = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  clr_overflow,
  input  logic                  tx_transmitting,
  input  logic                  tx_done,
  output logic                  full,
  output logic                  empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic [data_width-1:0] tx_data,
  output logic                  tx_run,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] mem_q [depth];
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic [data_width-1:0] tx_data_q, tx_data_d;
  logic                  tx_run_q, tx_run_d;
  logic                  push, pop;

  // full is the registered flag, so a write in a pop cycle is still dropped
  assign push = wr_en & ~full_q;
  assign pop  = (state_q == IDLE) & ~empty_q & ~tx_transmitting;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_done)              state_d = IDLE;
        else if (tx_transmitting) state_d = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(addr_width-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(addr_width-1){1'b0}}, pop};
    count_d    = count_q + {{addr_width{1'b0}}, push} - {{addr_width{1'b0}}, pop};
    full_d     = (count_d == (addr_width+1)'(depth));
    empty_d    = (count_d == '0);
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    tx_run_d   = (state_d == START);
    overflow_d = overflow_q;
    // a dropped write beats a same-cycle clear
    if (wr_en && full_q)   overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      tx_run_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_run_q   <= tx_run_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_run   = tx_run_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx model.
module tb_uart_tx_fifo;
  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_overflow = 1'b0;
  logic       tx_transmitting;
  logic       tx_done = 1'b0;
  logic       full, empty, overflow, tx_run, busy;
  logic [4:0] count;
  logic [7:0] tx_data;

  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;
  int         model_cnt = 0;
  int         frame_len = 100;

  int         n_chk = 0;
  int         n_fail = 0;
  int         run_cnt = 0;
  logic [7:0] exp_q[$];
  logic       outstanding = 1'b0;
  logic       prev_run = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  assign tx_transmitting = model_busy | force_busy;

  uart_tx_fifo dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .clr_overflow(clr_overflow), .tx_transmitting(tx_transmitting),
    .tx_done(tx_done), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .tx_data(tx_data), .tx_run(tx_run), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // uart_tx model: line goes busy the cycle after run, done pulses as it drops
  always @(posedge CLOCK_50) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_run) begin
        model_busy <= 1'b1;
        model_cnt  <= frame_len;
      end else if (model_busy) begin
        if (model_cnt <= 1) begin
          model_busy <= 1'b0;
          tx_done    <= 1'b1;
        end else model_cnt <= model_cnt - 1;
      end
    end
  end

  // monitor: every run pulse must carry the next expected byte
  always @(negedge CLOCK_50) begin
    if (rst) outstanding <= 1'b0;
    else begin
      if (tx_done) outstanding <= 1'b0;
      if (tx_run) begin
        run_cnt <= run_cnt + 1;
        outstanding <= 1'b1;
        chk("run_while_transmitting", {31'd0, tx_transmitting}, 32'd0);
        chk("run_before_done", {31'd0, outstanding}, 32'd0);
        chk("run_width", {31'd0, prev_run}, 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_run: tx_data %0h with empty scoreboard at %0t", tx_data, $time);
        end else chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      if (busy && prev_busy && tx_data !== prev_data) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_data_hold: changed %0h -> %0h while busy", prev_data, tx_data);
      end
    end
    prev_run  <= tx_run;
    prev_busy <= busy;
    prev_data <= tx_data;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit acc);
    wr_en   = 1'b1;
    wr_data = b;
    if (acc) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (empty && !busy && !tx_transmitting) break;
      tick();
    end
    chk("drain_in_time", {31'd0, (i < maxc)}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int i;
    // reset
    tick(); tick();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_tx_run", {31'd0, tx_run}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    tick();

    // single byte latency
    wr(8'hA5, 1);
    chk("single_count1", {27'd0, count}, 32'd1);
    chk("single_norun_c1", {31'd0, tx_run}, 32'd0);
    tick();
    chk("single_run_c2", {31'd0, tx_run}, 32'd1);
    chk("single_data_c2", {24'd0, tx_data}, 32'hA5);
    chk("single_busy_c2", {31'd0, busy}, 32'd1);
    chk("single_count_c2", {27'd0, count}, 32'd0);
    tick();
    chk("single_run_c3", {31'd0, tx_run}, 32'd0);
    for (i = 0; i < 200; i++) begin
      if (tx_done) break;
      tick();
    end
    chk("single_done_seen", {31'd0, (i < 200)}, 32'd1);
    chk("single_busy_at_done", {31'd0, busy}, 32'd1);
    tick();
    chk("single_idle_after_done", {31'd0, busy}, 32'd0);
    wait_drain(50);

    // burst ordering
    r0 = run_cnt;
    for (int b = 1; b <= 5; b++) wr(8'(b), 1);
    wait_drain(2000);
    chk("burst_runs", run_cnt - r0, 32'd5);
    chk("burst_empty", {31'd0, empty}, 32'd1);
    chk("burst_sb_empty", exp_q.size(), 32'd0);

    // full and overflow, wrapping the pointers
    frame_len = 5;
    force_busy = 1'b1;
    for (int b = 1; b <= 16; b++) wr(8'(b), 1);
    chk("full_count", {27'd0, count}, 32'd16);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_no_ovf", {31'd0, overflow}, 32'd0);
    wr(8'h11, 0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {27'd0, count}, 32'd16);
    clr_overflow = 1'b1;
    wr(8'h12, 0);
    clr_overflow = 1'b0;
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    force_busy = 1'b0;
    wr(8'hEE, 0);
    chk("full_pop_write_count", {27'd0, count}, 32'd15);
    chk("full_pop_write_ovf", {31'd0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    wait_drain(1000);
    chk("full_sb_empty", exp_q.size(), 32'd0);

    // simultaneous write and pop
    force_busy = 1'b1;
    wr(8'h31, 1); wr(8'h32, 1); wr(8'h33, 1);
    chk("sim_count_pre", {27'd0, count}, 32'd3);
    force_busy = 1'b0;
    wr(8'h34, 1);
    chk("sim_count_post", {27'd0, count}, 32'd3);
    wait_drain(500);
    chk("sim_sb_empty", exp_q.size(), 32'd0);

    // reset in WAIT_DONE
    frame_len = 100;
    force_busy = 1'b1;
    for (int b = 8'h41; b <= 8'h45; b++) wr(8'(b), 1);
    force_busy = 1'b0;
    for (i = 0; i < 20; i++) begin
      if (busy && tx_transmitting) break;
      tick();
    end
    chk("mid_reach_busy", {31'd0, (i < 20)}, 32'd1);
    tick();
    chk("mid_count4", {27'd0, count}, 32'd4);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("mid_count0", {27'd0, count}, 32'd0);
    chk("mid_empty", {31'd0, empty}, 32'd1);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    chk("mid_norun", {31'd0, tx_run}, 32'd0);
    r0 = run_cnt;
    repeat (20) tick();
    chk("mid_no_spurious_run", run_cnt, r0);
    wr(8'h77, 1);
    wait_drain(500);
    chk("mid_new_run", run_cnt, r0 + 1);
    chk("mid_sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
